// File: rtl/ir_pkg.sv
// Shared types and helpers for the instruction-register byte assembler.
package ir_pkg;

  typedef enum logic {
    FILL = 1'b0,
    FULL = 1'b1
  } ir_state_t;

  // Width of a lane index; never below 1 so single-lane builds still have a select bit.
  function automatic int calc_lb(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic int lane_index(input int count, input int n, input bit msb_first);
    return msb_first ? (n - 1 - count) : count;
  endfunction

endpackage

// File: rtl/ir_byte_assembler_if.sv
// Byte-in / instruction-out bus between the memory data path, the assembler and the control unit.
interface ir_byte_assembler_if
  import ir_pkg::*;
#(
  parameter int IR_WIDTH   = 16,
  parameter int BYTE_WIDTH = 8
);
  localparam int N  = IR_WIDTH / BYTE_WIDTH;
  localparam int LB = calc_lb(N);

  logic                  Mode;
  logic                  Flush;
  logic                  Write;
  logic [LB-1:0]         LaneSel;
  logic [BYTE_WIDTH-1:0] I;
  logic                  InValid;
  logic                  InReady;
  logic                  Consume;
  logic [IR_WIDTH-1:0]   IROut;
  logic                  IRValid;
  logic [LB:0]           LaneCount;

  modport master (
    output Mode, Flush, Write, LaneSel, I, InValid, Consume,
    input  InReady, IROut, IRValid, LaneCount
  );

  modport slave (
    input  Mode, Flush, Write, LaneSel, I, InValid, Consume,
    output InReady, IROut, IRValid, LaneCount
  );

endinterface

// File: rtl/ir_lane_sequencer.sv
// Auto-mode fill FSM: tracks accepted lanes, raises IRValid after the last byte's edge.
// InReady is combinational; in FULL it follows consume so a refill byte can land in the same cycle.
module ir_lane_sequencer
  import ir_pkg::*;
#(
  parameter int N         = 2,
  parameter int LB        = 1,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          mode,
  input  logic          flush,
  input  logic          in_vld,
  input  logic          consume,
  output logic          in_rdy,
  output logic          ir_vld,
  output logic          accept,
  output logic [LB:0]   lane_cnt,
  output logic [LB-1:0] wr_lane
);

  localparam int CW = LB + 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  ir_state_t     state, state_nxt;
  logic [CW-1:0] count, count_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= FILL;
      count <= '0;
    end else begin
      state <= state_nxt;
      count <= count_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    count_nxt = count;
    if (flush || !mode) begin
      state_nxt = FILL;
      count_nxt = '0;
    end else begin
      case (state)
        FILL: begin
          if (in_vld) begin
            if (count == LAST) begin
              state_nxt = FULL;
              count_nxt = '0;
            end else begin
              count_nxt = count + 1'b1;
            end
          end
        end
        FULL: begin
          if (consume) begin
            // A single-lane instruction is complete the moment its refill byte lands.
            if (in_vld && N == 1) begin
              state_nxt = FULL;
              count_nxt = '0;
            end else if (in_vld) begin
              state_nxt = FILL;
              count_nxt = CW'(1);
            end else begin
              state_nxt = FILL;
              count_nxt = '0;
            end
          end
        end
      endcase
    end
  end

  always_comb begin
    in_rdy = 1'b0;
    if (!flush && mode) begin
      in_rdy = (state == FILL) ? 1'b1 : consume;
    end
    ir_vld   = (state == FULL);
    accept   = in_vld & in_rdy;
    lane_cnt = count;
    // count is zero in FULL, so this also yields the first lane for a refill.
    wr_lane  = LB'(lane_index(int'(count), N, MSB_FIRST));
  end

endmodule

// File: rtl/ir_byte_assembler.sv
// Instruction register built from byte lanes; manual lane writes or auto-sequenced byte stream.
// Auto mode: IRValid one edge after the last accept; holds IROut and stalls input until Consume.
module ir_byte_assembler
  import ir_pkg::*;
#(
  parameter int IR_WIDTH   = 16,
  parameter int BYTE_WIDTH = 8,
  parameter bit MSB_FIRST  = 1'b1
) (
  input logic                Clock,
  input logic                Reset,
  ir_byte_assembler_if.slave bus
);

  localparam int N  = IR_WIDTH / BYTE_WIDTH;
  localparam int LB = calc_lb(N);

  if (IR_WIDTH % BYTE_WIDTH != 0) begin : g_bad_width
    $error("IR_WIDTH must be an integer multiple of BYTE_WIDTH");
  end

  logic [IR_WIDTH-1:0] ir_q;
  logic                seq_rdy;
  logic                seq_vld;
  logic                seq_accept;
  logic [LB:0]         seq_cnt;
  logic [LB-1:0]       seq_lane;
  logic                lane_we;
  logic [LB-1:0]       lane_idx;

  ir_lane_sequencer #(
    .N         (N),
    .LB        (LB),
    .MSB_FIRST (MSB_FIRST)
  ) u_seq (
    .clk      (Clock),
    .rst_n    (Reset),
    .mode     (bus.Mode),
    .flush    (bus.Flush),
    .in_vld   (bus.InValid),
    .consume  (bus.Consume),
    .in_rdy   (seq_rdy),
    .ir_vld   (seq_vld),
    .accept   (seq_accept),
    .lane_cnt (seq_cnt),
    .wr_lane  (seq_lane)
  );

  always_comb begin
    lane_we  = 1'b0;
    lane_idx = '0;
    if (!bus.Flush) begin
      if (!bus.Mode) begin
        lane_we  = bus.Write && (int'(bus.LaneSel) < N);
        lane_idx = bus.LaneSel;
      end else begin
        lane_we  = seq_accept;
        lane_idx = seq_lane;
      end
    end
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      ir_q <= '0;
    end else begin
      for (int k = 0; k < N; k++) begin
        if (lane_we && int'(lane_idx) == k) begin
          ir_q[k*BYTE_WIDTH +: BYTE_WIDTH] <= bus.I;
        end
      end
    end
  end

  assign bus.InReady   = seq_rdy;
  assign bus.IRValid   = seq_vld;
  assign bus.LaneCount = seq_cnt;
  assign bus.IROut     = ir_q;

endmodule
